// File: rtl/sort_pkg.sv
// Shared types and default sizing for the odd-even transposition sorter.
package sort_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_N      = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sort_cx.sv
// Compare-exchange cell: orders one adjacent pair when enabled, else passes it through.
module sort_cx
    import sort_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              desc,
    input  logic              en,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi
);

    logic swap_s;

    // Strict comparison so equal elements never move
    always_comb begin
        swap_s = 1'b0;
        lo     = a;
        hi     = b;
        if (en) begin
            if (desc) begin
                swap_s = (a < b);
            end else begin
                swap_s = (a > b);
            end
        end else begin
            swap_s = 1'b0;
        end
        if (swap_s) begin
            lo = b;
            hi = a;
        end else begin
            lo = a;
            hi = b;
        end
    end

endmodule

// File: rtl/sort_engine.sv
// Odd-even transposition sorter: accepts an N-element vector, runs exactly N
// phases (one per cycle), then presents the sorted vector with valid/ready.
module sort_engine
    import sort_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int N      = DEFAULT_N
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DATA_W-1:0] in_data,
    input  logic                in_desc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*DATA_W-1:0] out_data,
    output logic                busy
);

    localparam int               CNT_W      = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_PHASE = CNT_W'(N - 1);

    state_t                   state_r;
    state_t                   state_nx_s;
    logic [CNT_W-1:0]         phase_r;
    logic                     desc_r;
    logic [N-1:0][DATA_W-1:0] arr_r;
    logic [N-1:0][DATA_W-1:0] arr_nx_s;
    logic [N-2:0]             en_s;
    logic [N-2:0][DATA_W-1:0] lo_s;
    logic [N-2:0][DATA_W-1:0] hi_s;
    logic                     accept_s;

    assign in_ready  = (state_r == IDLE) | ((state_r == DONE) & out_ready);
    assign accept_s  = in_valid & in_ready;
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r == SORT);
    assign out_data  = arr_r;

    // Pair i is active on phases whose parity matches i
    for (genvar i = 0; i < N - 1; i++) begin : g_cx
        localparam logic PAIR_PAR = 1'(i % 2);
        assign en_s[i] = (phase_r[0] == PAIR_PAR);
        sort_cx #(
            .DATA_W(DATA_W)
        ) u_cx (
            .a   (arr_r[i]),
            .b   (arr_r[i+1]),
            .desc(desc_r),
            .en  (en_s[i]),
            .lo  (lo_s[i]),
            .hi  (hi_s[i])
        );
    end

    // Each interior element belongs to exactly one pair per phase: left pair's hi or right pair's lo
    for (genvar j = 0; j < N; j++) begin : g_el
        if (j == 0) begin : g_first
            assign arr_nx_s[j] = lo_s[0];
        end else if (j == N - 1) begin : g_last
            assign arr_nx_s[j] = hi_s[N-2];
        end else begin : g_mid
            assign arr_nx_s[j] = en_s[j-1] ? hi_s[j-1] : lo_s[j];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; DONE can hand off straight into a new SORT
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nx_s = SORT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SORT: begin
                if (phase_r == LAST_PHASE) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = SORT;
                end
            end
            DONE: begin
                if (out_ready & in_valid) begin
                    state_nx_s = SORT;
                end else if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Datapath: load on accept, one transposition phase per SORT cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arr_r   <= '0;
            phase_r <= '0;
            desc_r  <= 1'b0;
        end else if (accept_s) begin
            arr_r   <= in_data;
            phase_r <= '0;
            desc_r  <= in_desc;
        end else if (state_r == SORT) begin
            arr_r   <= arr_nx_s;
            phase_r <= phase_r + CNT_W'(1);
        end else begin
            arr_r   <= arr_r;
            phase_r <= phase_r;
            desc_r  <= desc_r;
        end
    end

endmodule
